sdp_ram_bytewr: RTL and testbench

Parametrised simple dual-port RAM, successor to the single-mode block: one write port with byte enables, one read port with an explicit read request. It adds a configurable read latency with per-request valid, a selectable read-during-write collision policy, and an optional zero-initialisation engine that runs after reset. It sits wherever a datapath needs a buffer with one write and one read port and a deterministic read-return timing.

---
 rtl/sdp_ram_pkg.sv | 34 +++
 rtl/sdp_ram_bytewr_if.sv | 28 ++
 rtl/sdp_ram_rd_pipe.sv | 54 +++++
 rtl/sdp_ram_bytewr.sv | 175 +++++++++++++++++
 tb/tb_sdp_ram_bytewr.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sdp_ram_pkg.sv
// Shared types and helpers for the byte-writable simple dual-port RAM.
// The byte-merge helper works on a maximum-width word so every instance can share it.
package sdp_ram_pkg;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } rdw_mode_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int MAX_DATA_WIDTH = 512;
    localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

    // Callers zero-extend their operands and truncate the result back to their own width.
    function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_BE_WIDTH-1:0]   be
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_BE_WIDTH; i++) begin
            if (be[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sdp_ram_bytewr_if.sv
// Write/read bus of the byte-writable simple dual-port RAM.
// The master drives requests; the slave (the RAM) returns read data and status.
interface sdp_ram_bytewr_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) ();

    logic                    wena;
    logic [DATA_WIDTH/8-1:0] wbe;
    logic [ADDR_WIDTH-1:0]   addra;
    logic [DATA_WIDTH-1:0]   dina;
    logic                    renb;
    logic [ADDR_WIDTH-1:0]   addrb;
    logic [DATA_WIDTH-1:0]   doutb;
    logic                    dvalb;
    logic                    init_busy;

    modport master (
        output wena, wbe, addra, dina, renb, addrb,
        input  doutb, dvalb, init_busy
    );

    modport slave (
        input  wena, wbe, addra, dina, renb, addrb,
        output doutb, dvalb, init_busy
    );

endinterface

// File: rtl/sdp_ram_rd_pipe.sv
// Read-return delay line: DEPTH register stages carrying data and valid.
// Only the valid bits are reset; each data stage loads only when its input is valid, so the tail holds.
module sdp_ram_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign out_valid = in_valid;
            assign out_data  = in_data;
        end else begin : g_pipe
            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                logic                  prev_valid;
                logic [DATA_WIDTH-1:0] prev_data;
                logic                  valid_reg;
                logic [DATA_WIDTH-1:0] data_reg;

                if (gi == 0) begin : g_first
                    assign prev_valid = in_valid;
                    assign prev_data  = in_data;
                end else begin : g_next
                    assign prev_valid = g_stage[gi-1].valid_reg;
                    assign prev_data  = g_stage[gi-1].data_reg;
                end

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        valid_reg <= 1'b0;
                    end else begin
                        valid_reg <= prev_valid;
                    end
                end

                always_ff @(posedge clk) begin
                    if (prev_valid) begin
                        data_reg <= prev_data;
                    end
                end
            end

            assign out_valid = g_stage[DEPTH-1].valid_reg;
            assign out_data  = g_stage[DEPTH-1].data_reg;
        end
    endgenerate

endmodule

// File: rtl/sdp_ram_bytewr.sv
// Simple dual-port RAM: byte-enabled write port, request-based read port with fixed latency,
// selectable read-during-write policy and an optional zero-fill engine that runs after reset.
module sdp_ram_bytewr
    import sdp_ram_pkg::*;
#(
    parameter int        DATA_WIDTH    = 32,
    parameter int        ADDR_WIDTH    = 8,
    parameter int        MEM_DEPTH     = 256,
    parameter int        RD_LATENCY    = 2,
    parameter rdw_mode_e RDW_MODE      = READ_FIRST,
    parameter int        INIT_ON_RESET = 1
) (
    input logic            clk,
    input logic            rst,
    sdp_ram_bytewr_if.slave bus
);

    localparam int                  BE_WIDTH    = DATA_WIDTH / 8;
    localparam int                  IDX_WIDTH   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W     = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam state_e              RESET_STATE = (INIT_ON_RESET != 0) ? INIT : RUN;

    generate
        if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_data_width
            $error("sdp_ram_bytewr: DATA_WIDTH must be a multiple of 8 between 8 and %0d", MAX_DATA_WIDTH);
        end
        if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_rd_latency
            $error("sdp_ram_bytewr: RD_LATENCY must be in 1..4");
        end
        if (ADDR_WIDTH < 1 || ADDR_WIDTH > 31 || MEM_DEPTH < 1 ||
            longint'(MEM_DEPTH) > (64'd1 << ADDR_WIDTH)) begin : g_bad_mem_depth
            $error("sdp_ram_bytewr: MEM_DEPTH must be in 1..2**ADDR_WIDTH");
        end
    endgenerate

    // ---------------------------------------------------------------- init FSM
    state_e                state_reg;
    logic [ADDR_WIDTH-1:0] init_cnt_reg;
    logic                  init_busy_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= RESET_STATE;
            init_cnt_reg  <= '0;
            init_busy_reg <= (RESET_STATE == INIT);
        end else begin
            case (state_reg)
                INIT: begin
                    if (init_cnt_reg == LAST_ADDR) begin
                        state_reg     <= RUN;
                        init_cnt_reg  <= '0;
                        init_busy_reg <= 1'b0;
                    end else begin
                        init_cnt_reg <= init_cnt_reg + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    init_busy_reg <= 1'b0;
                end
            endcase
        end
    end

    logic run;
    logic wr_in_range;
    logic rd_in_range;

    assign run         = (state_reg == RUN);
    assign wr_in_range = ({1'b0, bus.addra} < DEPTH_W);
    assign rd_in_range = ({1'b0, bus.addrb} < DEPTH_W);

    // ---------------------------------------------------------------- write port
    // The zero-fill engine borrows the write port while the FSM is in INIT.
    logic                  wr_en;
    logic [IDX_WIDTH-1:0]  wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BE_WIDTH-1:0]   wr_be;

    always_comb begin
        wr_en   = 1'b1;
        wr_idx  = init_cnt_reg[IDX_WIDTH-1:0];
        wr_data = '0;
        wr_be   = '1;
        if (run) begin
            wr_en   = bus.wena && wr_in_range && (|bus.wbe);
            wr_idx  = bus.addra[IDX_WIDTH-1:0];
            wr_data = bus.dina;
            wr_be   = bus.wbe;
        end
    end

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------- read port
    logic                  rd_accept;
    logic                  collide;
    logic [IDX_WIDTH-1:0]  rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    assign rd_accept = run && bus.renb;
    assign collide   = bus.wena && (bus.addra == bus.addrb);
    assign rd_idx    = bus.addrb[IDX_WIDTH-1:0];

    // Out-of-range reads return zero; WRITE_FIRST forwards the bytes being written this cycle.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_idx];
            if (RDW_MODE == WRITE_FIRST && collide) begin
                rd_word = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(mem[rd_idx]),
                                                 MAX_DATA_WIDTH'(bus.dina),
                                                 MAX_BE_WIDTH'(bus.wbe)));
            end
        end
    end

    logic                  rd_valid_s1_reg;
    logic [DATA_WIDTH-1:0] rd_data_s1_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_s1_reg <= 1'b0;
        end else begin
            rd_valid_s1_reg <= rd_accept;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_accept) begin
            rd_data_s1_reg <= rd_word;
        end
    end

    logic                  pipe_valid;
    logic [DATA_WIDTH-1:0] pipe_data;

    sdp_ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RD_LATENCY - 1)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_valid_s1_reg),
        .in_data   (rd_data_s1_reg),
        .out_valid (pipe_valid),
        .out_data  (pipe_data)
    );

    // Data registers are not reset, so doutb reads zero until the first return after reset.
    logic out_loaded_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_loaded_reg <= 1'b0;
        end else if (pipe_valid) begin
            out_loaded_reg <= 1'b1;
        end
    end

    assign bus.doutb     = (out_loaded_reg || pipe_valid) ? pipe_data : '0;
    assign bus.dvalb     = pipe_valid;
    assign bus.init_busy = init_busy_reg;

endmodule

// File: tb/tb_sdp_ram_bytewr.sv
// Self-checking bench: four RAM instances with different depth/latency/collision settings share one
// stimulus stream; a per-instance behavioural model predicts every cycle's outputs.
module tb_sdp_ram_bytewr;
    import sdp_ram_pkg::*;

    localparam int N_DUT = 4;

    function automatic int depth_of(input int d);
        return (d < 2) ? 16 : 200;
    endfunction

    function automatic int lat_of(input int d);
        return d + 1;
    endfunction

    function automatic bit wf_of(input int d);
        return (d % 2) == 1;
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        wena = 1'b0;
    logic        renb = 1'b0;
    logic [3:0]  wbe = '0;
    logic [7:0]  addra = '0;
    logic [7:0]  addrb = '0;
    logic [31:0] dina = '0;

    logic [31:0]      doutb_w [N_DUT];
    logic [N_DUT-1:0] dvalb_w;
    logic [N_DUT-1:0] busy_w;

    for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
        sdp_ram_bytewr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

        assign bus.wena  = wena;
        assign bus.wbe   = wbe;
        assign bus.addra = addra;
        assign bus.dina  = dina;
        assign bus.renb  = renb;
        assign bus.addrb = addrb;
        assign doutb_w[gi] = bus.doutb;
        assign dvalb_w[gi] = bus.dvalb;
        assign busy_w[gi]  = bus.init_busy;

        sdp_ram_bytewr #(
            .DATA_WIDTH    (32),
            .ADDR_WIDTH    (8),
            .MEM_DEPTH     (depth_of(gi)),
            .RD_LATENCY    (lat_of(gi)),
            .RDW_MODE      (wf_of(gi) ? WRITE_FIRST : READ_FIRST),
            .INIT_ON_RESET (1)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    // Reference model: word array, remaining zero-fill cycles, and a calendar of due read returns.
    logic [31:0] ref_mem [N_DUT][256];
    int          init_left [N_DUT];
    bit          sched_v [N_DUT][8];
    logic [31:0] sched_d [N_DUT][8];
    logic [31:0] last_d [N_DUT];
    int          pulse_cnt [N_DUT];
    int          first_pulse [N_DUT];
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    int          fails = 0;

    function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] be);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{be[b]}};
        return (o & ~mask) | (n & mask);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < N_DUT; d++) begin
            logic [31:0] r;
            if (!rst) continue;
            if (init_left[d] > 0) begin
                init_left[d]--;
                continue;
            end
            if (renb) begin
                r = '0;
                if (int'(addrb) < depth_of(d)) begin
                    r = ref_mem[d][addrb];
                    if (wf_of(d) && wena && addra == addrb) r = merge32(r, dina, wbe);
                end
                sched_v[d][(cyc + lat_of(d)) % 8] = 1'b1;
                sched_d[d][(cyc + lat_of(d)) % 8] = r;
            end
            if (wena && int'(addra) < depth_of(d))
                ref_mem[d][addra] = merge32(ref_mem[d][addra], dina, wbe);
        end
        cyc++;
    endtask

    task automatic check_outputs();
        for (int d = 0; d < N_DUT; d++) begin
            bit ev;
            ev = sched_v[d][cyc % 8];
            if (ev) begin
                last_d[d] = sched_d[d][cyc % 8];
                sched_v[d][cyc % 8] = 1'b0;
            end
            chk($sformatf("dut%0d dvalb c%0d", d, cyc), 32'(dvalb_w[d]), 32'(ev));
            chk($sformatf("dut%0d doutb c%0d", d, cyc), doutb_w[d], last_d[d]);
            chk($sformatf("dut%0d init_busy c%0d", d, cyc), 32'(busy_w[d]), 32'(init_left[d] > 0));
            if (dvalb_w[d]) begin
                if (pulse_cnt[d] == 0) first_pulse[d] = cyc;
                pulse_cnt[d]++;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic cycle(input bit w, input logic [3:0] be, input logic [7:0] aa,
                         input logic [31:0] d, input bit r, input logic [7:0] ab);
        wena = w; wbe = be; addra = aa; dina = d; renb = r; addrb = ab;
        step();
        wena = 1'b0; renb = 1'b0; wbe = '0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic assert_reset();
        rst = 1'b0;
        #1;
        for (int d = 0; d < N_DUT; d++) begin
            init_left[d] = depth_of(d);
            last_d[d]    = '0;
            pulse_cnt[d] = 0;
            for (int s = 0; s < 8; s++) sched_v[d][s] = 1'b0;
            for (int a = 0; a < 256; a++) ref_mem[d][a] = '0;
            chk($sformatf("dut%0d reset dvalb", d), 32'(dvalb_w[d]), 32'h0);
            chk($sformatf("dut%0d reset doutb", d), doutb_w[d], 32'h0);
            chk($sformatf("dut%0d reset init_busy", d), 32'(busy_w[d]), 32'h1);
        end
    endtask

    function automatic logic [7:0] pick_addr();
        return ($urandom_range(0, 7) == 0) ? 8'($urandom_range(190, 255)) : 8'($urandom_range(0, 19));
    endfunction

    initial begin
        int issue;
        @(negedge clk);
        assert_reset();
        wait_cycles(2);
        rst = 1'b1;

        // Requests while zero-filling must be ignored.
        cycle(1'b1, 4'hF, 8'd7, 32'hDEADBEEF, 1'b1, 8'd7);
        wait_cycles(205);

        for (int a = 0; a < 16; a++) cycle(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'(a));
        wait_cycles(6);

        cycle(1'b1, 4'hF, 8'd5, 32'hAABBCCDD, 1'b0, 8'd0);
        cycle(1'b1, 4'b0101, 8'd5, 32'h11223344, 1'b0, 8'd0);
        cycle(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd5);
        wait_cycles(6);
        for (int d = 0; d < N_DUT; d++) chk($sformatf("dut%0d byte merge", d), doutb_w[d], 32'hAA22CC44);

        cycle(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd7);
        wait_cycles(6);
        for (int d = 0; d < N_DUT; d++) chk($sformatf("dut%0d write during init", d), doutb_w[d], 32'h0);

        cycle(1'b1, 4'hF, 8'd3, 32'hFFFFFFFF, 1'b1, 8'd3);
        wait_cycles(6);
        for (int d = 0; d < N_DUT; d++)
            chk($sformatf("dut%0d collision", d), doutb_w[d], wf_of(d) ? 32'hFFFFFFFF : 32'h0);
        cycle(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd3);
        wait_cycles(6);
        for (int d = 0; d < N_DUT; d++) chk($sformatf("dut%0d after collision", d), doutb_w[d], 32'hFFFFFFFF);

        cycle(1'b1, 4'b1001, 8'd4, 32'h12345678, 1'b1, 8'd4);
        cycle(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd4);
        wait_cycles(6);

        for (int a = 0; a < 8; a++) cycle(1'b1, 4'hF, 8'(a), 32'hA5000000 + 32'(a * 17), 1'b0, 8'd0);
        for (int d = 0; d < N_DUT; d++) pulse_cnt[d] = 0;
        issue = cyc;
        for (int a = 0; a < 8; a++) cycle(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'(a));
        wait_cycles(8);
        for (int d = 0; d < N_DUT; d++) begin
            chk($sformatf("dut%0d sweep pulses", d), 32'(pulse_cnt[d]), 32'd8);
            chk($sformatf("dut%0d sweep latency", d), 32'(first_pulse[d] - issue), 32'(lat_of(d)));
        end

        cycle(1'b1, 4'hF, 8'd250, 32'hCAFEF00D, 1'b0, 8'd0);
        cycle(1'b1, 4'hF, 8'd100, 32'h0BADC0DE, 1'b0, 8'd0);
        cycle(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd250);
        wait_cycles(6);
        for (int d = 0; d < N_DUT; d++) chk($sformatf("dut%0d out of range read", d), doutb_w[d], 32'h0);
        cycle(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd100);
        wait_cycles(6);
        for (int d = 0; d < N_DUT; d++)
            chk($sformatf("dut%0d addr 100", d), doutb_w[d], (depth_of(d) > 100) ? 32'h0BADC0DE : 32'h0);

        for (int i = 0; i < 400; i++) begin
            logic [7:0] aa;
            aa = pick_addr();
            cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), aa, $urandom,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? aa : pick_addr());
        end
        wait_cycles(6);

        cycle(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd1);
        cycle(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd2);
        cycle(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd3);
        assert_reset();
        wait_cycles(6);
        for (int d = 0; d < N_DUT; d++) chk($sformatf("dut%0d lost reads", d), 32'(pulse_cnt[d]), 32'd0);
        rst = 1'b1;
        wait_cycles(205);
        cycle(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd3);
        wait_cycles(6);

        if (passes + fails != checks) $fatal(1, "check bookkeeping inconsistent");
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
